// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: synchronized scan strobe steps an active-low anode,
// shadowed hex value is decoded to active-low segments. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
  parameter  int DIGITS = 4,
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_clk,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic                 s1_r, s2_r, s3_r;
  logic                 scan_edge_s;
  logic [IDX_W-1:0]     idx_r, idx_next_s;
  logic [4*DIGITS-1:0]  shadow_val_r;
  logic [DIGITS-1:0]    shadow_dp_r;
  logic [3:0]           nibble_s;
  logic                 blank_s;
  logic [DIGITS-1:0]    an_next_s;
  logic [6:0]           seg_next_s;
  logic                 dp_next_s;

  // scan_clk is a level from another domain: two-flop synchronizer plus history for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= scan_clk;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign scan_edge_s = s2_r & ~s3_r;

  // next digit index: advance on rising scan edge, wrap at the last digit
  always_comb begin
    idx_next_s = idx_r;
    if (scan_edge_s) begin
      if (idx_r == IDX_W'(DIGITS-1)) begin
        idx_next_s = {IDX_W{1'b0}};
      end else begin
        idx_next_s = idx_r + IDX_W'(1);
      end
    end else begin
      idx_next_s = idx_r;
    end
  end

  // digit index and shadow registers; load and scan edge are independent and may coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r        <= {IDX_W{1'b0}};
      shadow_val_r <= {(4*DIGITS){1'b0}};
      shadow_dp_r  <= {DIGITS{1'b0}};
    end else begin
      idx_r <= idx_next_s;
      if (load) begin
        shadow_val_r <= value;
        shadow_dp_r  <= dp_in;
      end else begin
        shadow_val_r <= shadow_val_r;
        shadow_dp_r  <= shadow_dp_r;
      end
    end
  end

  assign nibble_s = shadow_val_r[{idx_r, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from_s[i] is set when nibbles i..DIGITS-1 are all zero
  logic [DIGITS-1:0] zero_from_s;

  // suffix-AND of per-nibble zero flags, built from the top digit downwards
  always_comb begin
    zero_from_s = {DIGITS{1'b0}};
    zero_from_s[DIGITS-1] = (shadow_val_r[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS-2; i >= 0; i--) begin
      zero_from_s[i] = zero_from_s[i+1] & (shadow_val_r[4*i +: 4] == 4'h0);
    end
  end

  assign blank_s = (idx_r != {IDX_W{1'b0}}) & zero_from_s[idx_r];
`else
  assign blank_s = 1'b0;
`endif

  // output decode from current index and shadow
  always_comb begin
    an_next_s = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_r);
    dp_next_s = ~shadow_dp_r[idx_r];
    if (blank_s) begin
      seg_next_s = 7'h7F;
    end else begin
      seg_next_s = ~hex7(nibble_s);
    end
  end

  // registered outputs, blank while in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= {DIGITS{1'b1}};
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next_s;
      seg <= seg_next_s;
      dp  <= dp_next_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: per-cycle behavioural model plus directed literal checks.
module tb_seg_scan_driver;

  localparam int DIGITS = 4;

  logic                 clk;
  logic                 rst;
  logic                 scan_clk;
  logic                 load;
  logic [4*DIGITS-1:0]  value;
  logic [DIGITS-1:0]    dp_in;
  logic [DIGITS-1:0]    an;
  logic [6:0]           seg;
  logic                 dp;

  int checks   = 0;
  int failures = 0;

  seg_scan_driver #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .scan_clk(scan_clk), .load(load),
    .value(value), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model state: what the display should show, derived from the observable input events
  int               m_idx;
  logic [3:0]       m_nib [DIGITS];
  logic [DIGITS-1:0] m_dp;
  logic             m_prev_scan;
  logic [1:0]       m_rise_dly;
  logic             m_blank;
  logic [DIGITS-1:0] exp_an;
  logic [6:0]       exp_seg;
  logic             exp_dp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: outputs follow the pre-edge index/shadow; a rise sampled at edge k moves the index at k+2
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx = 0;
      for (int j = 0; j < DIGITS; j++) m_nib[j] = 4'h0;
      m_dp = '0;
      m_prev_scan = 1'b0;
      m_rise_dly = 2'b00;
      exp_an = '1;
      exp_seg = 7'h7F;
      exp_dp = 1'b1;
    end else begin
      m_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx != 0) begin
        m_blank = 1'b1;
        for (int j = m_idx; j < DIGITS; j++) if (m_nib[j] != 4'h0) m_blank = 1'b0;
      end
`endif
      exp_an  = '1;
      exp_an[m_idx] = 1'b0;
      exp_seg = m_blank ? 7'h7F : ~hex_tab[m_nib[m_idx]];
      exp_dp  = ~m_dp[m_idx];
      if (m_rise_dly[1]) m_idx = (m_idx + 1) % DIGITS;
      m_rise_dly = {m_rise_dly[0], scan_clk & ~m_prev_scan};
      m_prev_scan = scan_clk;
      if (load) begin
        for (int j = 0; j < DIGITS; j++) m_nib[j] = value[4*j +: 4];
        m_dp = dp_in;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("model", {25'd0, an, seg, dp}, {25'd0, exp_an, exp_seg, exp_dp});
  end

  // one full scan step: low gap, rise, wait until the new digit is on the outputs
  task automatic adv();
    repeat (2) @(negedge clk);
    scan_clk = 1'b1;
    repeat (4) @(negedge clk);
    scan_clk = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp);
    chk({name, "_an"},  {28'd0, an},  {28'd0, e_an});
    chk({name, "_seg"}, {25'd0, seg}, {25'd0, e_seg});
    chk({name, "_dp"},  {31'd0, dp},  {31'd0, e_dp});
  endtask

  initial begin
    rst = 1'b1; scan_clk = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    chk_out("in_reset", 4'b1111, 7'h7F, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk_out("post_reset", 4'b1110, 7'h40, 1'b1);
    repeat (20) @(negedge clk);
    chk_out("idle_hold", 4'b1110, 7'h40, 1'b1);

    value = 16'h1234; dp_in = 4'b0010; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk_out("loaded_d0", 4'b1110, 7'h19, 1'b1);
    repeat (2) @(negedge clk);
    scan_clk = 1'b1;
    repeat (3) @(negedge clk);
    chk_out("k_plus2", 4'b1110, 7'h19, 1'b1);
    @(negedge clk);
    chk_out("k_plus3", 4'b1101, 7'h30, 1'b0);
    scan_clk = 1'b0;

    adv(); chk_out("digit2", 4'b1011, 7'h24, 1'b1);
    adv(); chk_out("digit3", 4'b0111, 7'h79, 1'b1);
    adv(); chk_out("wrap0",  4'b1110, 7'h19, 1'b1);
    adv(); chk_out("digit1", 4'b1101, 7'h30, 1'b0);

    repeat (2) @(negedge clk);
    scan_clk = 1'b1;
    repeat (10000) @(negedge clk);
    chk_out("held_high", 4'b1011, 7'h24, 1'b1);
    scan_clk = 1'b0;

    adv(); adv();
    chk_out("back_to0", 4'b1110, 7'h19, 1'b1);
    repeat (2) @(negedge clk);
    scan_clk = 1'b1;
    repeat (2) @(negedge clk);
    value = 16'hABCD; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk_out("load_and_edge", 4'b1101, 7'h46, 1'b1);
    scan_clk = 1'b0;

    value = 16'h0050; dp_in = 4'b0100; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk_out("z_digit1", 4'b1101, 7'h12, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    adv(); chk_out("z_digit2", 4'b1011, 7'h7F, 1'b0);
    adv(); chk_out("z_digit3", 4'b0111, 7'h7F, 1'b1);
`else
    adv(); chk_out("z_digit2", 4'b1011, 7'h40, 1'b0);
    adv(); chk_out("z_digit3", 4'b0111, 7'h40, 1'b1);
`endif
    adv(); chk_out("z_digit0", 4'b1110, 7'h40, 1'b1);
    adv();

    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_out("async_rst", 4'b1111, 7'h7F, 1'b1);
    @(negedge clk);
    chk_out("rst_held", 4'b1111, 7'h7F, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk_out("restart", 4'b1110, 7'h40, 1'b1);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
